// File: rtl/host_reg_bridge.sv
// Host-bus bridge: synchronised M1 host strobes into config/command/status/result
// registers, plus a timed read/write sequencer that gives the host access to SRAM.
module host_reg_bridge #(
  parameter int N_CFG    = 24,
  parameter int N_RES    = 8,
  parameter int CMD_W    = 4,
  parameter int SRAM_AW  = 18,
  parameter int WAIT_CYC = 2
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                HOST_nCS,
  input  logic                HOST_nWE,
  input  logic                HOST_nOE,
  input  logic [20:0]         HOST_ADD,
  input  logic [15:0]         HDI,
  output logic [15:0]         HDO,
  output logic [16*N_CFG-1:0] cfg_regs,
  output logic [CMD_W-1:0]    proc_cmd,
  output logic                proc_start,
  input  logic [3:0]          proc_status,
  input  logic [16*N_RES-1:0] proc_result,
  inout  wire  [15:0]         SRAM_DATA,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_nCS,
  output logic                SRAM_nOE,
  output logic                SRAM_nWE
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_PULSE, RD_DONE
  } sram_state_e;

  sram_state_e state, state_nxt;

  logic [1:0]  cs_sync, we_sync, oe_sync;
  logic        wr_cond, rd_cond, wr_cond_q, rd_cond_q, wr_ev, rd_ev;
  logic [18:0] word_sel;
  logic        sram_win, cmd_hit, stat_hit;
  logic        reg_wr, reg_rd, sram_ev, sram_wr, sram_rd, sram_busy;
  logic [N_CFG-1:0] cfg_hit;
  logic [15:0] cfg_q [N_CFG];
  logic [CMD_W-1:0] cmd_q;
  logic        overrun;
  logic [15:0] rd_data;
  logic [3:0]  wait_cnt;
  logic [15:0] sram_wdata;
  logic        sram_drv, rd_capture, pulse_entry;
  logic        ncs_d, nwe_d, noe_d, drv_d;
  logic        unused_lsb;

  assign unused_lsb = HOST_ADD[0];

  // Host strobes are asynchronous: two-flop synchronise, then edge-detect the
  // decoded condition so each strobe assertion produces exactly one event.
  always_ff @(posedge clk) begin
    if (RESET) begin
      cs_sync   <= '1;
      we_sync   <= '1;
      oe_sync   <= '1;
      wr_cond_q <= 1'b0;
      rd_cond_q <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], HOST_nCS};
      we_sync   <= {we_sync[0], HOST_nWE};
      oe_sync   <= {oe_sync[0], HOST_nOE};
      wr_cond_q <= wr_cond;
      rd_cond_q <= rd_cond;
    end
  end

  assign wr_cond = !cs_sync[1] && !we_sync[1] &&  oe_sync[1];
  assign rd_cond = !cs_sync[1] && !oe_sync[1] &&  we_sync[1];
  assign wr_ev   = wr_cond && !wr_cond_q;
  assign rd_ev   = rd_cond && !rd_cond_q;

  assign word_sel = HOST_ADD[19:1];
  assign sram_win = HOST_ADD[20];
  assign cmd_hit  = word_sel == 19'h00800;
  assign stat_hit = word_sel == 19'h00801;
  assign reg_wr   = wr_ev && !sram_win;
  assign reg_rd   = rd_ev && !sram_win;
  assign sram_ev  = (wr_ev || rd_ev) && sram_win;

  always_comb begin
    cfg_hit = '0;
    for (int unsigned i = 0; i < N_CFG; i++)
      cfg_hit[i] = word_sel == 19'(i);
  end

  always_comb begin
    rd_data = '0;
    if (cmd_hit)
      rd_data = 16'(cmd_q);
    if (stat_hit)
      rd_data = {10'b0, overrun, sram_busy, proc_status};
    for (int unsigned i = 0; i < N_CFG; i++)
      if (cfg_hit[i]) rd_data = cfg_q[i];
    for (int unsigned j = 0; j < N_RES; j++)
      if (word_sel == 19'(32'h880 + j)) rd_data = proc_result[16*j +: 16];
  end

  always_comb begin
    cfg_regs = '0;
    for (int unsigned i = 0; i < N_CFG; i++)
      cfg_regs[16*i +: 16] = cfg_q[i];
  end

  assign proc_cmd = cmd_q;

  // An SRAM read completion owns HDO over a coincident register read.
  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int unsigned i = 0; i < N_CFG; i++) cfg_q[i] <= '0;
      cmd_q      <= '0;
      proc_start <= 1'b0;
      overrun    <= 1'b0;
      HDO        <= '0;
    end else begin
      proc_start <= reg_wr && cmd_hit && HDI[0];
      if (reg_wr) begin
        for (int unsigned i = 0; i < N_CFG; i++)
          if (cfg_hit[i]) cfg_q[i] <= HDI;
        if (cmd_hit) cmd_q <= HDI[CMD_W-1:0];
      end
      if (rd_capture)
        HDO <= SRAM_DATA;
      else if (reg_rd)
        HDO <= rd_data;
      if (sram_ev && sram_busy)
        overrun <= 1'b1;
      else if (reg_rd && stat_hit)
        overrun <= 1'b0;
    end
  end

  assign sram_busy   = state != IDLE;
  assign sram_wr     = wr_ev && sram_win && !sram_busy;
  assign sram_rd     = rd_ev && sram_win && !sram_busy;
  assign rd_capture  = (state == RD_PULSE) && (wait_cnt == '0);
  assign pulse_entry = (state_nxt != state) &&
                       (state_nxt == WR_PULSE || state_nxt == RD_PULSE);
  assign SRAM_DATA   = sram_drv ? sram_wdata : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      SRAM_ADDR  <= '0;
      sram_wdata <= '0;
      SRAM_nCS   <= 1'b1;
      SRAM_nWE   <= 1'b1;
      SRAM_nOE   <= 1'b1;
      sram_drv   <= 1'b0;
    end else begin
      state    <= state_nxt;
      SRAM_nCS <= ncs_d;
      SRAM_nWE <= nwe_d;
      SRAM_nOE <= noe_d;
      sram_drv <= drv_d;
      if (sram_wr || sram_rd) SRAM_ADDR <= HOST_ADD[SRAM_AW:1];
      if (sram_wr) sram_wdata <= HDI;
      if (pulse_entry)
        wait_cnt <= 4'(WAIT_CYC - 1);
      else if (wait_cnt != '0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sram_wr)      state_nxt = WR_SETUP;
        else if (sram_rd) state_nxt = RD_SETUP;
      end
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (wait_cnt == '0) state_nxt = WR_HOLD;
      WR_HOLD:  state_nxt = IDLE;
      RD_SETUP: state_nxt = RD_PULSE;
      RD_PULSE: if (wait_cnt == '0) state_nxt = RD_DONE;
      RD_DONE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so pins never glitch.
  always_comb begin
    ncs_d = 1'b1;
    nwe_d = 1'b1;
    noe_d = 1'b1;
    drv_d = 1'b0;
    case (state_nxt)
      WR_SETUP, WR_HOLD: begin
        ncs_d = 1'b0;
        drv_d = 1'b1;
      end
      WR_PULSE: begin
        ncs_d = 1'b0;
        nwe_d = 1'b0;
        drv_d = 1'b1;
      end
      RD_SETUP: ncs_d = 1'b0;
      RD_PULSE: begin
        ncs_d = 1'b0;
        noe_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_host_reg_bridge.sv
// Directed-vector bench for host_reg_bridge with a small SRAM model on the pins.
module tb_host_reg_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         RESET;
  logic         HOST_nCS, HOST_nWE, HOST_nOE;
  logic [20:0]  HOST_ADD;
  logic [15:0]  HDI;
  logic [15:0]  HDO;
  logic [383:0] cfg_regs;
  logic [3:0]   proc_cmd;
  logic         proc_start;
  logic [3:0]   proc_status;
  logic [127:0] proc_result;
  wire  [15:0]  SRAM_DATA;
  logic [17:0]  SRAM_ADDR;
  logic         SRAM_nCS, SRAM_nOE, SRAM_nWE;

  host_reg_bridge #(
    .N_CFG(24), .N_RES(8), .CMD_W(4), .SRAM_AW(18), .WAIT_CYC(2)
  ) dut (
    .clk(clk), .RESET(RESET),
    .HOST_nCS(HOST_nCS), .HOST_nWE(HOST_nWE), .HOST_nOE(HOST_nOE),
    .HOST_ADD(HOST_ADD), .HDI(HDI), .HDO(HDO),
    .cfg_regs(cfg_regs), .proc_cmd(proc_cmd), .proc_start(proc_start),
    .proc_status(proc_status), .proc_result(proc_result),
    .SRAM_DATA(SRAM_DATA), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_nCS(SRAM_nCS), .SRAM_nOE(SRAM_nOE), .SRAM_nWE(SRAM_nWE)
  );

  logic [15:0] mem [256];
  assign SRAM_DATA = (!SRAM_nCS && !SRAM_nOE) ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

  int unsigned we_lo_n = 0, oe_lo_n = 0, drv_n = 0, start_n = 0, bad_n = 0;
  logic [17:0] wr_addr_seen = '0;

  // Pin monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!SRAM_nWE) begin
      we_lo_n      <= we_lo_n + 1;
      wr_addr_seen <= SRAM_ADDR;
      if (!SRAM_nCS) mem[SRAM_ADDR[7:0]] <= SRAM_DATA;
    end
    if (!SRAM_nOE)     oe_lo_n <= oe_lo_n + 1;
    if (dut.sram_drv)  drv_n   <= drv_n + 1;
    if (proc_start)    start_n <= start_n + 1;
    if ((!SRAM_nWE && !SRAM_nOE) || (dut.sram_drv && !SRAM_nOE)) bad_n <= bad_n + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [20:0] a, input logic [15:0] d);
    @(negedge clk);
    HOST_ADD = a;
    HDI      = d;
    HOST_nCS = 1'b0;
    HOST_nWE = 1'b0;
    repeat (6) @(negedge clk);
    HOST_nWE = 1'b1;
    HOST_nCS = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic host_read(input logic [20:0] a, input int hold, output logic [15:0] d);
    @(negedge clk);
    HOST_ADD = a;
    HOST_nCS = 1'b0;
    HOST_nOE = 1'b0;
    repeat (hold) @(posedge clk);
    #1 d = HDO;
    @(negedge clk);
    HOST_nOE = 1'b1;
    HOST_nCS = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [15:0] rd;
  int unsigned b_we, b_oe, b_drv, b_st;

  initial begin
    RESET = 1'b1;
    HOST_nCS = 1'b1; HOST_nWE = 1'b1; HOST_nOE = 1'b1;
    HOST_ADD = '0; HDI = '0; proc_status = 4'h0;
    for (int j = 0; j < 8; j++) proc_result[16*j +: 16] = 16'hC000 + 16'(j);

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hdo",   HDO, 16'h0000);
    check_val("rst_cfg",   {31'b0, |cfg_regs}, 0);
    check_val("rst_cmd",   proc_cmd, 4'h0);
    check_val("rst_start", proc_start, 1'b0);
    check_val("rst_ncs",   SRAM_nCS, 1'b1);
    check_val("rst_nwe",   SRAM_nWE, 1'b1);
    check_val("rst_noe",   SRAM_nOE, 1'b1);
    check_val("rst_addr",  SRAM_ADDR, 18'h0);
    check_val("rst_drv",   dut.sram_drv, 1'b0);
    @(negedge clk);
    RESET = 1'b0;
    repeat (2) @(negedge clk);
    host_read(21'h001002, 4, rd);
    check_val("rst_status", rd, 16'h0000);

    // Config registers, including last-register and just-past-end boundaries
    host_write(21'h000006, 16'hBEEF);
    check_val("cfg3_bus", cfg_regs[63:48], 16'hBEEF);
    host_read(21'h000006, 4, rd);
    check_val("cfg3_rd", rd, 16'hBEEF);
    host_read(21'h00FFFE, 4, rd);
    check_val("unmapped_rd", rd, 16'h0000);
    host_write(21'h00002E, 16'h1357);
    host_write(21'h000030, 16'hFFFF);
    check_val("cfg23_bus", cfg_regs[383:368], 16'h1357);
    check_val("cfg2_bus", cfg_regs[47:32], 16'h0000);
    host_read(21'h000030, 4, rd);
    check_val("cfg_past_end", rd, 16'h0000);

    // Command register and start pulse
    b_st = start_n;
    host_write(21'h001000, 16'h0005);
    check_val("cmd5", proc_cmd, 4'h5);
    check_val("start_pulse", start_n - b_st, 1);
    b_st = start_n;
    host_write(21'h001000, 16'h0004);
    check_val("cmd4", proc_cmd, 4'h4);
    check_val("no_pulse4", start_n - b_st, 0);
    b_st = start_n;
    host_write(21'h001000, 16'hFFF6);
    check_val("no_pulse6", start_n - b_st, 0);
    host_read(21'h001000, 4, rd);
    check_val("cmd_rd", rd, 16'h0006);

    // Result window and read-only behaviour
    host_read(21'h001100, 4, rd);
    check_val("res0", rd, 16'hC000);
    host_read(21'h00110E, 4, rd);
    check_val("res7", rd, 16'hC007);
    host_read(21'h001110, 4, rd);
    check_val("res_past_end", rd, 16'h0000);
    host_write(21'h001100, 16'h1111);
    host_read(21'h001100, 4, rd);
    check_val("res0_ro", rd, 16'hC000);

    // SRAM write then read back
    b_we = we_lo_n; b_drv = drv_n;
    host_write(21'h100010, 16'h1234);
    check_val("sram_wr_addr", wr_addr_seen, 18'h00008);
    check_val("sram_we_cyc", we_lo_n - b_we, 2);
    check_val("sram_drv_cyc", drv_n - b_drv, 4);
    check_val("sram_mem", mem[8], 16'h1234);
    check_val("sram_idle_ncs", SRAM_nCS, 1'b1);
    b_oe = oe_lo_n; b_drv = drv_n;
    host_read(21'h100010, 7, rd);
    check_val("sram_rd", rd, 16'h1234);
    check_val("sram_oe_cyc", oe_lo_n - b_oe, 2);
    check_val("sram_rd_nodrv", drv_n - b_drv, 0);

    // Overrun: second SRAM write lands while the first is still in its pulse
    proc_status = 4'h3;
    b_we = we_lo_n;
    @(negedge clk);
    HOST_ADD = 21'h100020; HDI = 16'h5555; HOST_nCS = 1'b0; HOST_nWE = 1'b0;
    repeat (2) @(negedge clk);
    HOST_nWE = 1'b1;
    @(negedge clk);
    HOST_ADD = 21'h100030; HDI = 16'hAAAA; HOST_nWE = 1'b0;
    repeat (5) @(negedge clk);
    HOST_nWE = 1'b1; HOST_nCS = 1'b1;
    repeat (4) @(negedge clk);
    check_val("ovr_we_cyc", we_lo_n - b_we, 2);
    check_val("ovr_addr", wr_addr_seen, 18'h00010);
    check_val("ovr_mem", mem[16], 16'h5555);
    host_read(21'h001002, 4, rd);
    check_val("ovr_status1", rd, 16'h0023);
    host_read(21'h001002, 4, rd);
    check_val("ovr_status2", rd, 16'h0003);

    // Reset in the middle of a write pulse
    @(negedge clk);
    HOST_ADD = 21'h100040; HDI = 16'h7777; HOST_nCS = 1'b0; HOST_nWE = 1'b0;
    repeat (4) @(negedge clk);
    check_val("mid_we_low", SRAM_nWE, 1'b0);
    RESET = 1'b1; HOST_nCS = 1'b1; HOST_nWE = 1'b1;
    @(negedge clk);
    check_val("mid_nwe", SRAM_nWE, 1'b1);
    check_val("mid_ncs", SRAM_nCS, 1'b1);
    check_val("mid_drv", dut.sram_drv, 1'b0);
    check_val("mid_busy", dut.sram_busy, 1'b0);
    @(negedge clk);
    RESET = 1'b0;
    repeat (3) @(negedge clk);
    host_read(21'h001002, 4, rd);
    check_val("mid_status", rd, 16'h0003);

    check_val("strobe_rules", bad_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/host_reg_bridge.md
Name: host_reg_bridge

Overview:
Parametrised host-bus bridge between the M1 host bus and the FPGA datapath. It replaces the fixed host interface and provides:
- a configurable bank of 16-bit config registers;
- a command register with a start pulse;
- read-only status and result windows;
- a timed SRAM read/write FSM that lets the host reach external SRAM.

It sits between the host pins and the processing core and SRAM pins.

Parameters:
N_CFG, 24, number of 16-bit config registers at host offsets 0x00000..2*(N_CFG-1); 1..64
N_RES, 8, number of 16-bit read-only result words at offsets 0x01100..; 1..16
CMD_W, 4, width of proc_cmd
SRAM_AW, 18, SRAM word-address width
WAIT_CYC, 2, SRAM access-pulse length in clk cycles; 1..15

Ports:
clk  in  1  system clock
RESET  in  1  synchronous, active-high reset
HOST_nCS  in  1  host chip select, async to clk
HOST_nWE  in  1  host write strobe, async
HOST_nOE  in  1  host read strobe, async
HOST_ADD  in  21  host byte address
HDI  in  16  host write data
HDO  out  16  host read data (registered)
cfg_regs  out  16*N_CFG  flat config bus; reg i at [16i+15:16i]
proc_cmd  out  CMD_W  command register low bits
proc_start  out  1  one-cycle pulse on a command write with HDI[0]=1
proc_status  in  4  core status, readable in the status word
proc_result  in  16*N_RES  core result words
SRAM_DATA  inout  16  SRAM data; driven only in write states, else Z
SRAM_ADDR  out  SRAM_AW  SRAM word address
SRAM_nCS  out  1  SRAM select, active low
SRAM_nOE  out  1  SRAM output enable, active low
SRAM_nWE  out  1  SRAM write enable, active low

Behaviour:
- Reset (sync, RESET=1 at posedge):
  - outputs: HDO=0, all cfg regs=0, proc_cmd=0, proc_start=0; SRAM_nCS/nOE/nWE=1, SRAM_ADDR=0, SRAM_DATA=Z;
  - state: FSM=IDLE, overrun flag=0, synchronisers=1.
  - Reset mid-SRAM-cycle aborts immediately, with strobes deasserted the next edge.
- Host sync:
  - nCS, nWE, nOE pass through 2-flop synchronisers.
  - wr_ev = first cycle where synced nCS=0, nWE=0, nOE=1. rd_ev = first cycle where synced nCS=0, nOE=0.
  - HOST_ADD and HDI are sampled in the wr_ev/rd_ev cycle; the host holds them stable during the strobe.
  - One event per strobe assertion. Both strobes low: no event.
- Decode (byte offset = HOST_ADD[19:0]; HOST_ADD[0] ignored):
  - HOST_ADD[20]=1 -> SRAM window, word address = HOST_ADD[SRAM_AW:1].
  - 0x00000 + 2i, i<N_CFG -> cfg reg i (R/W).
  - 0x01000 -> command (R/W, CMD_W bits, upper bits read 0).
  - 0x01002 -> status (RO): {10'b0, overrun, sram_busy, proc_status}.
  - 0x01100 + 2j, j<N_RES -> result j (RO).
  - Unmapped: writes ignored, reads return 0x0000. Writes to RO addresses are ignored.
- Register write: the target is updated on the clk edge after wr_ev. A command write with HDI[0]=1 also pulses proc_start high for exactly that one cycle. proc_cmd = cmd[CMD_W-1:0].
- Register read: HDO is loaded on the edge after rd_ev. Latency from nOE fall to HDO valid is ≤ 4 clk. A status read clears overrun on the same edge; the returned value shows the pre-clear bit.
- SRAM FSM: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_PULSE, RD_DONE.
  - IDLE: a SRAM-window wr_ev -> WR_SETUP, a SRAM-window rd_ev -> RD_SETUP; latch address and data.
  - WR_SETUP (1 cyc): nCS=0, ADDR valid, DATA driven.
  - WR_PULSE (WAIT_CYC cyc): nWE=0.
  - WR_HOLD (1 cyc): nWE=1, DATA still driven, then -> IDLE with nCS=1 and DATA=Z.
  - RD_SETUP (1 cyc): nCS=0, ADDR valid.
  - RD_PULSE (WAIT_CYC cyc): nOE=0; SRAM_DATA is captured on the last cycle.
  - RD_DONE (1 cyc): HDO=captured word, strobes=1, -> IDLE.
  - sram_busy=1 whenever state≠IDLE.
  - nWE and nOE are never low together. DATA is never driven while nOE=0.
- Overrun: a SRAM-window event while sram_busy=1 is dropped and sets overrun=1 (sticky). Register-window events are still serviced during an SRAM cycle.
- WAIT_CYC counter is 4 bits and reloads on each entry to a PULSE state.

Test Plan:
- Reset: RESET=1 for 2 cycles -> HDO=0, cfg_regs=0, all SRAM strobes=1, SRAM_DATA=Z; status read -> 0x0000 with proc_status=0.
- Config R/W: write 0xBEEF to 0x00006, then read 0x00006 -> HDO=0xBEEF ≤4 clk after nOE fall; cfg_regs[63:48]=0xBEEF; read 0x0FFFE -> 0x0000.
- Command: write 0x0005 to 0x01000 -> proc_cmd=4'h5, proc_start high exactly 1 cycle; write 0x0004 -> no pulse.
- SRAM write/read, WAIT_CYC=2: write 0x1234 at HOST_ADD=0x100010 -> SRAM_ADDR=0x00008, nWE low exactly 2 cycles, data driven setup+pulse+hold. Read back the same address -> HDO=0x1234; nOE low 2 cycles; DATA=Z throughout the read.
- Overrun: issue a second SRAM write while busy -> the second write is not performed; status bit5=1; a second status read -> bit5=0.
- Mid-op reset: assert RESET during WR_PULSE -> next edge nWE=nCS=1, DATA=Z, FSM IDLE, sram_busy=0.
